// File: rtl/digit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   - state_t    : FSM state encoding (IDLE, RUN, DONE)
//   - ndig_of    : number of digit slices per operation (WIDTH / DIGIT)
//   - cnt_width_of : digit-counter width, clog2(NDIG) but never below 1
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig_of(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width_of(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage : adder_pkg

// File: rtl/digit_serial_adder_ripple_digit.sv
// -----------------------------------------------------------------------------
// ripple_digit
// DIGIT-bit ripple-carry slice built from one-bit full-adder cells.
// Ports:
//   a, b  in  DIGIT  slice operands (b already inverted for subtract)
//   cin   in  1      carry into bit 0
//   sum   out DIGIT  slice sum
//   cout  out 1      carry out of the top bit
//   cmsb  out 1      carry into the top bit (overflow detection)
// -----------------------------------------------------------------------------
module ripple_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // c_s[i] is the carry into bit i; c_s[DIGIT] leaves the slice.
  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[DIGIT];
  assign cmsb = c_s[DIGIT-1];

endmodule : ripple_digit

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
// Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits per clock,
// least-significant digit first, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   Sub, Cin, A, B    mode, carry/borrow-in and operands, sampled at accept
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   S, Cout, V, Z     result, carry/not-borrow, signed overflow, zero flag
// -----------------------------------------------------------------------------
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int NDIG = ndig_of(WIDTH, DIGIT);
  localparam int CW   = cnt_width_of(NDIG);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [WIDTH-1:0]  s_r;
  logic              cout_r;
  logic              v_r;
  logic              z_r;

  logic [DIGIT-1:0]  sum_s;
  logic              cout_s;
  logic              cmsb_s;
  logic [WIDTH-1:0]  a_rot_s;
  logic [WIDTH-1:0]  b_rot_s;
  logic [WIDTH-1:0]  res_s;

  ripple_digit #(.DIGIT(DIGIT)) u_slice (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  if (NDIG > 1) begin : g_multi
    // Digits already produced; the newest digit enters at the top so that
    // after NDIG cycles {sum_s, acc_r} is the full result in order.
    logic [WIDTH-DIGIT-1:0] acc_r;

    assign res_s   = {sum_s, acc_r};
    // Operands rotate so the next digit is always in the low slice.
    assign a_rot_s = {a_r[DIGIT-1:0], a_r[WIDTH-1:DIGIT]};
    assign b_rot_s = {b_r[DIGIT-1:0], b_r[WIDTH-1:DIGIT]};

    // Result accumulator: shifts one digit down per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_r <= {(WIDTH-DIGIT){1'b0}};
      end else if (state_r == RUN) begin
        acc_r <= res_s[WIDTH-1:DIGIT];
      end else begin
        acc_r <= acc_r;
      end
    end
  end else begin : g_single
    assign res_s   = sum_s;
    assign a_rot_s = a_r;
    assign b_rot_s = b_r;
  end

  // Control FSM, operand registers, carry chain state and result/flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      s_r     <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      v_r     <= 1'b0;
      z_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + ~Cin, so invert B and the borrow here.
            a_r     <= A;
            b_r     <= Sub ? ~B : B;
            carry_r <= Cin ^ Sub;
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_rot_s;
          b_r     <= b_rot_s;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            s_r     <= res_s;
            cout_r  <= cout_s;
            v_r     <= cout_s ^ cmsb_s;
            z_r     <= (res_s == {WIDTH{1'b0}});
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign S         = s_r;
  assign Cout      = cout_r;
  assign V         = v_r;
  assign Z         = z_r;

endmodule : digit_serial_adder

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
// Scoreboard bench for digit_serial_adder: a 32/8 instance and an 8/8
// (single-digit) instance. Expected results come from an arithmetic model
// and are queued at accept, then popped when the result appears.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, v, z;
  logic [31:0] a, b, s;

  logic        in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, v8, z8;
  logic [7:0]  a8, b8, s8;

  exp_t sb_q[$];
  exp_t sb8_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sub(sub), .Cin(cin), .A(a), .B(b), .out_valid(out_valid),
    .out_ready(out_ready), .S(s), .Cout(cout), .V(v), .Z(z)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .Sub(sub8), .Cin(cin8), .A(a8), .B(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .S(s8), .Cout(cout8), .V(v8), .Z(z8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model32(input logic sub_i, input logic cin_i,
                                   input logic [31:0] a_i, input logic [31:0] b_i);
    logic [31:0] bx;
    logic [32:0] full;
    exp_t e;
    bx    = sub_i ? ~b_i : b_i;
    full  = {1'b0, a_i} + {1'b0, bx} + {32'd0, (sub_i ? ~cin_i : cin_i)};
    e.s   = full[31:0];
    e.c   = full[32];
    e.v   = (a_i[31] == bx[31]) && (e.s[31] != a_i[31]);
    e.z   = (e.s == 32'd0);
    return e;
  endfunction

  function automatic exp_t model8(input logic sub_i, input logic cin_i,
                                  input logic [7:0] a_i, input logic [7:0] b_i);
    logic [7:0] bx;
    logic [8:0] full;
    exp_t e;
    bx    = sub_i ? ~b_i : b_i;
    full  = {1'b0, a_i} + {1'b0, bx} + {8'd0, (sub_i ? ~cin_i : cin_i)};
    e.s   = {24'd0, full[7:0]};
    e.c   = full[8];
    e.v   = (a_i[7] == bx[7]) && (full[7] != a_i[7]);
    e.z   = (full[7:0] == 8'd0);
    return e;
  endfunction

  task automatic accept32(input logic sub_i, input logic cin_i,
                          input logic [31:0] a_i, input logic [31:0] b_i);
    int n;
    sub = sub_i; cin = cin_i; a = a_i; b = b_i; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(model32(sub_i, cin_i, a_i, b_i));
  endtask

  task automatic wait_result32(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic compare32(input string tag);
    exp_t e;
    check({tag, "_sb_size"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_S"}, s, e.s);
      check({tag, "_Cout"}, 32'(cout), 32'(e.c));
      check({tag, "_V"}, 32'(v), 32'(e.v));
      check({tag, "_Z"}, 32'(z), 32'(e.z));
    end
  endtask

  task automatic consume32();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic full_op32(input string tag, input logic sub_i, input logic cin_i,
                           input logic [31:0] a_i, input logic [31:0] b_i);
    int lat;
    accept32(sub_i, cin_i, a_i, b_i);
    wait_result32(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    compare32(tag);
    consume32();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e_bp;
    exp_t e8;
    int   lat;
    int   n;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; cin = 1'b0; a = 32'd0; b = 32'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_S", s, 32'd0);
    check("rst_flags", 32'({cout, v, z}), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst8_in_ready", 32'(in_ready8), 32'd1);

    // Directed cases
    full_op32("add_wrap", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    full_op32("sub_neg",  1'b1, 1'b0, 32'd5, 32'd7);
    full_op32("add_ovf",  1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    full_op32("sub_bin",  1'b1, 1'b1, 32'd7, 32'd7);
    full_op32("sub_pos",  1'b1, 1'b1, 32'd10, 32'd3);
    full_op32("sub_zero", 1'b1, 1'b0, 32'h0001_2345, 32'h0001_2345);
    full_op32("sub_ovf",  1'b1, 1'b0, 32'h8000_0000, 32'd1);
    full_op32("add_cin",  1'b0, 1'b1, 32'h00FF_00FF, 32'h0000_FF00);

    // Random cases
    for (int i = 0; i < 6; i++) begin
      full_op32("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom), 32'($urandom));
    end

    // Backpressure: result held while new operands wait
    accept32(1'b0, 1'b0, 32'h1111_2222, 32'h3333_4444);
    wait_result32(lat);
    e_bp = sb_q[0];
    a = 32'h1234_0000; b = 32'h0000_5678; sub = 1'b0; cin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_S", s, e_bp.s);
      check("bp_flags", 32'({cout, v, z}), 32'({e_bp.c, e_bp.v, e_bp.z}));
    end
    compare32("bp_first");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    sb_q.push_back(model32(1'b0, 1'b1, 32'h1234_0000, 32'h0000_5678));
    wait_result32(lat);
    check("bp_second_latency", 32'(lat), 32'd4);
    compare32("bp_second");
    // Leave this result in DONE; the reset below must clear it.

    // Reset mid-RUN: consume, start an op, reset after two digits
    consume32();
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_S", s, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_flags", 32'({cout, v, z}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    full_op32("after_rst", 1'b0, 1'b0, 32'd3, 32'd4);

    // Single-digit instance
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("w8_accept_ready", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    sb8_q.push_back(model8(1'b0, 1'b1, 8'h80, 8'h80));
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("w8_timeout", 32'(out_valid8), 32'd1);
    check("w8_latency", 32'(lat), 32'd1);
    check("w8_sb_size", 32'(sb8_q.size()), 32'd1);
    if (sb8_q.size() != 0) begin
      e8 = sb8_q.pop_front();
      check("w8_S", 32'(s8), e8.s);
      check("w8_Cout", 32'(cout8), 32'(e8.c));
      check("w8_V", 32'(v8), 32'(e8.v));
      check("w8_Z", 32'(z8), 32'(e8.z));
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("w8_post_hs_out_valid", 32'(out_valid8), 32'd0);
    check("w8_post_hs_in_ready", 32'(in_ready8), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_digit_serial_adder

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor. It computes a WIDTH-bit sum or difference one DIGIT-bit slice per clock, least-significant slice first, using a small ripple-carry slice adder. Operands enter and results leave through valid/ready handshakes. It serves wide datapaths where a full-width ripple chain would not meet timing, and it adds subtract mode plus overflow and zero flags.

## Interface
- WIDTH, 32: operand and result width; WIDTH % DIGIT must equal 0.
- DIGIT, 8: bits processed per cycle; NDIG = WIDTH/DIGIT cycles per operation.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- Sub  in  1  0 selects add, 1 selects subtract; sampled at accept.
- Cin  in  1  carry-in (add) or borrow-in (subtract); sampled at accept.
- A  in  WIDTH  operand A; sampled at accept.
- B  in  WIDTH  operand B; sampled at accept.
- out_valid  out  1  result valid; held until it is consumed.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  result.
- Cout  out  1  carry-out (add), or not-borrow (subtract).
- V  out  1  signed two's-complement overflow.
- Z  out  1  S == 0.

## Operation
- States:
  - IDLE: in_ready = 1.
  - RUN: NDIG cycles.
  - DONE: out_valid = 1.
- IDLE → RUN on in_valid && in_ready. At that point, latch:
  - A
  - B' = Sub ? ~B : B
  - carry = Sub ? ~Cin : Cin
  - digit counter = 0
- Result definitions:
  - Add: {Cout,S} = A + B + Cin.
  - Subtract: {Cout,S} = A + ~B + ~Cin, so S = A − B − Cin, and Cout = 1 iff A ≥ B + Cin (unsigned).
- Each RUN cycle:
  - The slice adder combines DIGIT bits of A and B' with the carry register.
  - The sum digit is shifted into S from the top.
  - The carry register is updated and the counter increments.
- On the last digit (counter == NDIG−1):
  - Capture Cout = final carry.
  - V = carry into MSB XOR carry out of MSB; both are taken from the last slice.
  - Z = (final S == 0).
  - Go to DONE.
- DONE → IDLE on out_ready. S, Cout, V and Z keep their values until the next operation's final digit.
- Signals ignored outside their sampling point:
  - A, B, Sub and Cin while in RUN or DONE.
  - in_valid while in_ready = 0.
  - out_ready outside DONE.
- Reset asserted at any time, including mid-RUN or in DONE:
  - State returns to IDLE immediately and the operation is discarded.
  - S = 0, Cout = 0, V = 0, Z = 0, out_valid = 0, in_ready = 1.

## Timing
- Accept at edge t.
- Digit k is computed at edge t+1+k.
- out_valid rises after edge t+NDIG. Latency = NDIG cycles.
- Output handshake at edge u: out_valid is low and in_ready high from edge u. The earliest next accept is edge u+1.
- Maximum throughput: one operation per NDIG+2 cycles.
- NDIG = 1 (DIGIT = WIDTH): a single RUN cycle, and out_valid rises after edge t+1.
- in_ready and out_valid are decoded from registered state only; there is no combinational in→out path.
- The critical path is one DIGIT-bit ripple chain plus the carry register.

## Structure
- Shared package adder_pkg holds:
  - the state encoding (IDLE, RUN, DONE)
  - the NDIG and counter-width derivation (clog2 of NDIG, minimum 1)
- Sub-module ripple_digit holds:
  - parameter DIGIT
  - a chain of one-bit full-adder cells
  - outputs: sum digit, carry out, and carry into the top bit (used for V).
- The top level holds the FSM, counter, operand/result shift registers and flag logic.
- Elaboration check: WIDTH % DIGIT != 0 is an error.

## Test plan
- WIDTH=32, DIGIT=8, add:
  - Stimulus: A=0xFFFFFFFF, B=0x00000001, Cin=0.
  - Required: S=0x00000000, Cout=1, Z=1, V=0; out_valid rises exactly 4 cycles after accept.
- Subtract:
  - Stimulus: Sub=1, A=5, B=7, Cin=0.
  - Required: S=0xFFFFFFFE, Cout=0, V=0, Z=0.
- Overflow:
  - Stimulus: A=0x7FFFFFFF, B=1, Cin=0, add.
  - Required: S=0x80000000, V=1, Cout=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: S and flags stable, in_ready=0, new operands not taken. Release out_ready and the new operands are accepted one cycle later.
- Reset mid-RUN:
  - Stimulus: assert rst after 2 digits.
  - Required: out_valid=0, S=0, in_ready=1 immediately. A fresh op A=3, B=4 then yields S=7.
- WIDTH=8, DIGIT=8:
  - Stimulus: A=0x80, B=0x80, Cin=1.
  - Required: S=0x01, Cout=1, V=1; out_valid one cycle after accept.
